// File: rtl/n_term_wire_loop_checker_if.sv
// Southbound drive, northbound return and run-control/status bundle of the
// north-edge wire loop checker.
interface n_term_wire_loop_checker_if;
    logic        start;
    logic [3:0]  lat;
    logic [15:0] num_vectors;

    logic [3:0]  S1BEG;
    logic [7:0]  S2BEG;
    logic [7:0]  S2BEGb;
    logic [15:0] S4BEG;
    logic [15:0] SS4BEG;

    logic [3:0]  N1END;
    logic [7:0]  N2MID;
    logic [7:0]  N2END;
    logic [15:0] N4END;
    logic [15:0] NN4END;

    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [15:0] first_err_vec;
    logic [2:0]  first_err_bundle;

    modport master (
        output start, lat, num_vectors, N1END, N2MID, N2END, N4END, NN4END,
        input  S1BEG, S2BEG, S2BEGb, S4BEG, SS4BEG,
        input  busy, done, pass, err_count, first_err_vec, first_err_bundle
    );

    modport slave (
        input  start, lat, num_vectors, N1END, N2MID, N2END, N4END, NN4END,
        output S1BEG, S2BEG, S2BEGb, S4BEG, SS4BEG,
        output busy, done, pass, err_count, first_err_vec, first_err_bundle
    );
endinterface

// File: rtl/n_term_wire_loop_checker.sv
// Drives LFSR vectors down a fabric column and checks the bit-reversed loopback
// from the south terminal tile after a programmable round-trip latency.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | drives 0, waiting for start
// ST_RUN    | one new vector driven per cycle, num_vectors in total
// ST_DRAIN  | drives 0 while the last lat vectors come back and compare
// ST_REPORT | single cycle: pulse done, latch pass
module n_term_wire_loop_checker #(
    parameter logic [63:0] SEED    = 64'h0000_0000_0000_0001,
    parameter int          MAX_LAT = 15
) (
    input  logic UserCLK,
    input  logic Reset,
    n_term_wire_loop_checker_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    logic [1:0]  state;
    logic [63:0] lfsr;
    logic [63:0] lfsr_next;
    logic [3:0]  lat_eff;
    logic [3:0]  lat_q;
    logic [3:0]  sel;
    logic [15:0] vec_rem;
    logic [15:0] vec_idx;
    logic [3:0]  drain_cnt;

    // Stage 0 is the registered drive itself; stage k holds it k cycles later.
    logic [MAX_LAT-1:0][51:0] dly_vec;
    logic [MAX_LAT-1:0]       dly_vld;
    logic [MAX_LAT-1:0][15:0] dly_idx;

    logic [51:0] ret_word;
    logic [51:0] diff;
    logic [4:0]  bad;
    logic        cmp_vld;
    logic [4:0]  cmp_bad;
    logic [15:0] cmp_idx;
    logic [2:0]  first_bundle;

    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [15:0] err_count_q;
    logic [15:0] first_err_vec_q;
    logic [2:0]  first_err_bundle_q;

    assign lfsr_next = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};

    always_comb begin
        lat_eff = bus.lat;
        if (bus.lat == 4'd0)
            lat_eff = 4'd1;
        else if (int'(bus.lat) > MAX_LAT)
            lat_eff = 4'(MAX_LAT);
    end

    // Undo the per-bundle index reversal so returns line up with drive bits.
    always_comb begin
        ret_word = '0;
        for (int i = 0; i < 4; i++)
            ret_word[i] = bus.N1END[3-i];
        for (int i = 0; i < 8; i++) begin
            ret_word[4+i]  = bus.N2MID[7-i];
            ret_word[12+i] = bus.N2END[7-i];
        end
        for (int i = 0; i < 16; i++) begin
            ret_word[20+i] = bus.N4END[15-i];
            ret_word[36+i] = bus.NN4END[15-i];
        end
    end

    assign sel  = lat_q - 4'd1;
    assign diff = ret_word ^ dly_vec[sel];
    assign bad  = {|diff[51:36], |diff[35:20], |diff[19:12], |diff[11:4], |diff[3:0]};

    always_comb begin
        first_bundle = 3'd0;
        for (int b = 4; b >= 0; b--)
            if (cmp_bad[b]) first_bundle = 3'(b);
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            state              <= ST_IDLE;
            lfsr               <= SEED;
            lat_q              <= 4'd1;
            vec_rem            <= '0;
            vec_idx            <= '0;
            drain_cnt          <= '0;
            dly_vec            <= '0;
            dly_vld            <= '0;
            dly_idx            <= '0;
            cmp_vld            <= 1'b0;
            cmp_bad            <= '0;
            cmp_idx            <= '0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            pass_q             <= 1'b0;
            err_count_q        <= '0;
            first_err_vec_q    <= '0;
            first_err_bundle_q <= '0;
        end else begin
            done_q  <= 1'b0;
            busy_q  <= (state == ST_RUN) || (state == ST_DRAIN);

            dly_vec <= {dly_vec[MAX_LAT-2:0], (state == ST_RUN) ? lfsr[51:0] : 52'd0};
            dly_vld <= {dly_vld[MAX_LAT-2:0], state == ST_RUN};
            dly_idx <= {dly_idx[MAX_LAT-2:0], vec_idx};

            cmp_vld <= dly_vld[sel];
            cmp_bad <= dly_vld[sel] ? bad : 5'd0;
            cmp_idx <= dly_idx[sel];

            if (cmp_vld && (|cmp_bad)) begin
                if (err_count_q == 16'd0) begin
                    first_err_vec_q    <= cmp_idx;
                    first_err_bundle_q <= first_bundle;
                end
                if (err_count_q != 16'hFFFF)
                    err_count_q <= err_count_q + 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        lat_q              <= lat_eff;
                        lfsr               <= SEED;
                        vec_rem            <= bus.num_vectors;
                        vec_idx            <= '0;
                        drain_cnt          <= lat_eff;
                        err_count_q        <= '0;
                        first_err_vec_q    <= '0;
                        first_err_bundle_q <= '0;
                        state <= (bus.num_vectors == 16'd0) ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    lfsr    <= lfsr_next;
                    vec_idx <= vec_idx + 16'd1;
                    vec_rem <= vec_rem - 16'd1;
                    if (vec_rem == 16'd1)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_cnt == 4'd0)
                        state <= ST_REPORT;
                    else
                        drain_cnt <= drain_cnt - 4'd1;
                end
                default: begin
                    done_q <= 1'b1;
                    pass_q <= (err_count_q == 16'd0);
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.S1BEG            = dly_vec[0][3:0];
    assign bus.S2BEG            = dly_vec[0][11:4];
    assign bus.S2BEGb           = dly_vec[0][19:12];
    assign bus.S4BEG            = dly_vec[0][35:20];
    assign bus.SS4BEG           = dly_vec[0][51:36];
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_count_q;
    assign bus.first_err_vec    = first_err_vec_q;
    assign bus.first_err_bundle = first_err_bundle_q;

endmodule

// File: tb/tb_n_term_wire_loop_checker.sv
// Bench for the wire loop checker: a behavioural south-tile loopback with
// configurable delay and fault injection, checked against a vector-level model.
`timescale 1ns/1ps
module tb_n_term_wire_loop_checker;

    localparam logic [63:0] SEED = 64'h0000_0000_0000_0001;

    logic UserCLK = 1'b0;
    logic Reset   = 1'b1;

    n_term_wire_loop_checker_if bus();

    n_term_wire_loop_checker #(.SEED(SEED), .MAX_LAT(15)) dut (
        .UserCLK (UserCLK),
        .Reset   (Reset),
        .bus     (bus)
    );

    always #5 UserCLK = ~UserCLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Loopback environment state
    int          model_m   = 0;
    int          fault_vec = -1;
    bit          stuck_n1  = 1'b0;
    bit          run_on    = 1'b0;
    int          cyc       = -100;
    int          cur_n     = 0;
    logic [51:0] hist_w [8];
    int          hist_t [8];
    logic [51:0] vecs [$];

    function automatic logic [51:0] drive_word();
        return {bus.SS4BEG, bus.S4BEG, bus.S2BEGb, bus.S2BEG, bus.S1BEG};
    endfunction

    always @(negedge UserCLK) begin
        logic [51:0] r;
        for (int k = 7; k > 0; k--) begin
            hist_w[k] = hist_w[k-1];
            hist_t[k] = hist_t[k-1];
        end
        hist_w[0] = drive_word();
        hist_t[0] = (run_on && cyc >= 1 && cyc <= cur_n) ? cyc - 1 : -1;
        r = hist_w[model_m];
        if (fault_vec >= 0 && hist_t[model_m] == fault_vec) r[30] = ~r[30];
        if (stuck_n1) r[3:0] = 4'hF;
        for (int i = 0; i < 4; i++)  bus.N1END[i]  = r[3-i];
        for (int i = 0; i < 8; i++)  bus.N2MID[i]  = r[4+7-i];
        for (int i = 0; i < 8; i++)  bus.N2END[i]  = r[12+7-i];
        for (int i = 0; i < 16; i++) bus.N4END[i]  = r[20+15-i];
        for (int i = 0; i < 16; i++) bus.NN4END[i] = r[36+15-i];
    end

    task automatic gen_vecs(input int n);
        logic [63:0] s;
        s = SEED;
        vecs.delete();
        for (int v = 0; v < n; v++) begin
            vecs.push_back(s[51:0]);
            s = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
        end
    endtask

    // Vector v is checked against whatever the loopback returns lat cycles after
    // it was driven: the word driven at vector slot v+lat-1-m, or zero outside the run.
    task automatic expect_run(input int n, input int l, input int m, input int fv, input bit stk,
                              output logic [15:0] e_cnt, output logic [15:0] e_vec,
                              output logic [2:0] e_bun);
        int cnt;
        logic [51:0] got, d;
        cnt = 0; e_vec = 0; e_bun = 0;
        for (int v = 0; v < n; v++) begin
            int gi;
            gi  = v + l - 1 - m;
            got = (gi >= 0 && gi < n) ? vecs[gi] : 52'd0;
            if (fv >= 0 && gi == fv) got[30] = ~got[30];
            if (stk) got[3:0] = 4'hF;
            d = got ^ vecs[v];
            if (d != 52'd0) begin
                if (cnt == 0) begin
                    e_vec = 16'(v);
                    if      (d[3:0]   != 0) e_bun = 3'd0;
                    else if (d[11:4]  != 0) e_bun = 3'd1;
                    else if (d[19:12] != 0) e_bun = 3'd2;
                    else if (d[35:20] != 0) e_bun = 3'd3;
                    else                    e_bun = 3'd4;
                end
                cnt++;
            end
        end
        e_cnt = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
    endtask

    task automatic run_case(input string name, input int n, input int l, input int m,
                            input int fv, input bit stk, input bit chk_drv,
                            input int restart_at, input int reset_at);
        int done_cyc, budget, l_eff;
        bit busy_at_done, aborted, saw_done;
        logic [15:0] e_cnt, e_vec;
        logic [2:0]  e_bun;
        l_eff = (l == 0) ? 1 : l;
        gen_vecs(n);
        expect_run(n, l_eff, m, fv, stk, e_cnt, e_vec, e_bun);
        model_m = m; fault_vec = fv; stuck_n1 = stk; cur_n = n; cyc = -1;
        @(negedge UserCLK);
        bus.start = 1'b1; bus.lat = 4'(l); bus.num_vectors = 16'(n); run_on = 1'b1;
        @(posedge UserCLK);
        cyc = 0;
        done_cyc = -1; budget = n + 40; aborted = 1'b0; busy_at_done = 1'b1;
        while (done_cyc < 0 && cyc < budget && !aborted) begin
            @(negedge UserCLK);
            bus.start = (cyc == restart_at);
            if (cyc == restart_at) bus.num_vectors = 16'd3;
            if (cyc == 0) chk({name, " busy_c0"}, 64'(bus.busy), 64'd0);
            if (cyc == 1 && reset_at < 0) chk({name, " busy_c1"}, 64'(bus.busy), 64'd1);
            if (chk_drv && cyc >= 1 && cyc <= n && !(reset_at >= 0 && cyc >= reset_at))
                chk({name, " drive"}, 64'(drive_word()), 64'(vecs[cyc-1]));
            if (n == 0) chk({name, " drive_zero"}, 64'(drive_word()), 64'd0);
            if (cyc == reset_at - 1) Reset = 1'b1;
            if (cyc == reset_at) begin
                chk({name, " rst_busy"}, 64'(bus.busy), 64'd0);
                chk({name, " rst_drive"}, 64'(drive_word()), 64'd0);
                chk({name, " rst_err"}, 64'(bus.err_count), 64'd0);
                chk({name, " rst_done"}, 64'(bus.done), 64'd0);
                Reset = 1'b0;
                aborted = 1'b1;
            end
            if (bus.done) begin
                done_cyc = cyc;
                busy_at_done = bus.busy;
            end
            @(posedge UserCLK);
            cyc++;
        end
        if (aborted) begin
            saw_done = 1'b0;
            repeat (n + 30) begin
                @(negedge UserCLK);
                if (bus.done) saw_done = 1'b1;
            end
            chk({name, " no_done"}, 64'(saw_done), 64'd0);
        end else begin
            chk({name, " done_cycle"}, 64'(done_cyc), 64'(n + l_eff + 2));
            chk({name, " busy_at_done"}, 64'(busy_at_done), 64'd0);
            @(negedge UserCLK);
            chk({name, " done_width"}, 64'(bus.done), 64'd0);
            chk({name, " err_count"}, 64'(bus.err_count), 64'(e_cnt));
            chk({name, " pass"}, 64'(bus.pass), 64'(e_cnt == 16'd0));
            chk({name, " first_vec"}, 64'(bus.first_err_vec), 64'(e_vec));
            chk({name, " first_bundle"}, 64'(bus.first_err_bundle), 64'(e_bun));
        end
        run_on = 1'b0; cyc = -100; fault_vec = -1; stuck_n1 = 1'b0; model_m = 0;
        repeat (6) @(negedge UserCLK);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            hist_w[k] = '0;
            hist_t[k] = -1;
        end
        bus.start = 1'b0; bus.lat = 4'd1; bus.num_vectors = 16'd0;
        Reset = 1'b1;
        repeat (3) @(negedge UserCLK);
        chk("reset busy",   64'(bus.busy), 64'd0);
        chk("reset done",   64'(bus.done), 64'd0);
        chk("reset pass",   64'(bus.pass), 64'd0);
        chk("reset err",    64'(bus.err_count), 64'd0);
        chk("reset fvec",   64'(bus.first_err_vec), 64'd0);
        chk("reset fbun",   64'(bus.first_err_bundle), 64'd0);
        chk("reset drive",  64'(drive_word()), 64'd0);
        Reset = 1'b0;
        repeat (8) @(negedge UserCLK);

        run_case("ideal",      16,  1, 0, -1, 1'b0, 1'b1, -1, -1);
        run_case("fault_v3",   16,  1, 0,  3, 1'b0, 1'b0,  5, -1);
        run_case("lat2_ok",   100,  2, 1, -1, 1'b0, 1'b0, -1, -1);
        run_case("lat2_bad",  100,  1, 1, -1, 1'b0, 1'b0, -1, -1);
        run_case("n0",          0,  3, 0, -1, 1'b0, 1'b0, -1, -1);
        run_case("rst_mid",    16,  1, 0, -1, 1'b0, 1'b1, -1,  8);
        run_case("after_rst",  16,  1, 0, -1, 1'b0, 1'b1, -1, -1);
        run_case("lat0",        8,  0, 0, -1, 1'b0, 1'b0, -1, -1);
        for (int t = 0; t < 6; t++) begin
            int n, l, m, fv;
            n  = $urandom_range(1, 40);
            l  = $urandom_range(0, 15);
            m  = $urandom_range(0, 3);
            fv = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
            run_case($sformatf("rand%0d", t), n, l, m, fv, 1'b0, 1'b1, -1, -1);
        end
        run_case("stuck_n1", 65535, 1, 0, -1, 1'b1, 1'b0, 100, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
